// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial bus slaves.
//   DEF_ADDR_LEN / DEF_DATA_LEN / DEF_BURST_LEN : default field widths
//   state_t                                     : bram_slave FSM encoding
// RWAIT is only reachable when BRAM_SLAVE_WAIT_EN is defined. It keeps its
// encoding in every build so the state values do not shift between builds.
package bus_pkg;
  localparam int DEF_ADDR_LEN  = 12;
  localparam int DEF_DATA_LEN  = 8;
  localparam int DEF_BURST_LEN = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WDATA  = 3'd2,
    WSTORE = 3'd3,
    RFETCH = 3'd4,
    RWAIT  = 3'd5,
    RDATA  = 3'd6,
    DONE   = 3'd7
  } state_t;
endpackage

// File: rtl/bram_4k.sv
// Single-port synchronous RAM, 2**ADDR_LEN x DATA_LEN.
//   clk  : clock
//   we   : write enable, writes din to mem[addr]
//   addr : read/write address
//   din  : write data
//   dout : registered read of mem[addr] (read-before-write), 1-cycle latency
// The contents have no reset, so a bus reset leaves stored data intact.
module bram_4k
  import bus_pkg::*;
#(
  parameter int ADDR_LEN = DEF_ADDR_LEN,
  parameter int DATA_LEN = DEF_DATA_LEN
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [DATA_LEN-1:0] din,
  output logic [DATA_LEN-1:0] dout
);
  logic [DATA_LEN-1:0] mem [2**ADDR_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/bram_slave.sv
// Bit-serial bus slave in front of a 4K x 8 block RAM (interconnect slave 3).
//   clk, reset         : bus clock, synchronous active-high reset
//   master_valid       : master drives a valid bit on rx_address/rx_burst/rx_data
//   master_ready       : master takes the current tx_data bit
//   read_en, write_en  : transaction request, exactly one high to start
//   rx_address/rx_burst/rx_data : serial inputs, LSB first
//   slave_ready        : high in IDLE/ADDR/WDATA (serial input accepted)
//   slave_valid        : tx_data carries a read bit (RDATA only)
//   tx_data            : serial read data, LSB first
//   split_en           : tied low, this slave never splits
//   slave_delay [5:0]  : only with BRAM_SLAVE_WAIT_EN; wait cycles inserted
//                        after each RFETCH, sampled in RFETCH (0 = no wait)
// Optional feature macro: BRAM_SLAVE_WAIT_EN.
// Transaction: one start cycle in IDLE (serial data bits ignored), ADDR_LEN
// address/burst bits, then burst words. A burst count of 0 moves one word.
// The address increments after every word and wraps at 2**ADDR_LEN.
module bram_slave
  import bus_pkg::*;
#(
  parameter int ADDR_LEN  = DEF_ADDR_LEN,
  parameter int DATA_LEN  = DEF_DATA_LEN,
  parameter int BURST_LEN = DEF_BURST_LEN  // must equal ADDR_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic master_valid,
  input  logic master_ready,
  input  logic read_en,
  input  logic write_en,
  input  logic rx_address,
  input  logic rx_burst,
  input  logic rx_data,
  output logic slave_ready,
  output logic slave_valid,
  output logic tx_data,
  output logic split_en
`ifdef BRAM_SLAVE_WAIT_EN
  ,
  input  logic [5:0] slave_delay
`endif
);
  localparam int MAX_LEN = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN);

  state_t               state, state_n;
  logic                 is_read;
  logic [ADDR_LEN-1:0]  addr;
  logic [BURST_LEN-2:0] burst_lo;    // all burst bits but the last one
  logic [BURST_LEN-1:0] burst_full;
  logic [BURST_LEN-1:0] remaining;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_LEN-1:0]  shift;
  logic [DATA_LEN-1:0]  ram_dout;
  logic [DATA_LEN-1:0]  rd_word;
  logic                 fresh;       // RAM output not yet moved into shift
  logic                 ram_we;
  logic                 addr_last;
  logic                 data_last;
`ifdef BRAM_SLAVE_WAIT_EN
  logic [5:0]           wait_cnt;
`endif

  assign addr_last  = (cnt == CNT_W'(ADDR_LEN - 1));
  assign data_last  = (cnt == CNT_W'(DATA_LEN - 1));
  // The final burst bit arrives together with the final address bit, so
  // the full count is assembled from the live input on that cycle.
  assign burst_full = {rx_burst, burst_lo};
  // The first bit of a fetched word comes straight from the RAM output;
  // later bits come from the shift register.
  assign rd_word    = fresh ? ram_dout : shift;
  assign split_en   = 1'b0;

  bram_4k #(.ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (addr),
    .din  (shift),
    .dout (ram_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    slave_ready = 1'b0;
    slave_valid = 1'b0;
    tx_data     = 1'b0;
    ram_we      = 1'b0;
    case (state)
      IDLE: begin
        slave_ready = 1'b1;
        if (master_valid && (read_en ^ write_en)) state_n = ADDR;
      end
      ADDR: begin
        slave_ready = 1'b1;
        if (master_valid && addr_last) state_n = is_read ? RFETCH : WDATA;
      end
      WDATA: begin
        slave_ready = 1'b1;
        if (master_valid && data_last) state_n = WSTORE;
      end
      WSTORE: begin
        ram_we  = 1'b1;
        state_n = (remaining == BURST_LEN'(1)) ? DONE : WDATA;
      end
      RFETCH: begin
`ifdef BRAM_SLAVE_WAIT_EN
        state_n = (slave_delay == 6'd0) ? RDATA : RWAIT;
`else
        state_n = RDATA;
`endif
      end
      RWAIT: begin
`ifdef BRAM_SLAVE_WAIT_EN
        if (wait_cnt == 6'd1) state_n = RDATA;
`else
        state_n = IDLE;
`endif
      end
      RDATA: begin
        slave_valid = 1'b1;
        tx_data     = rd_word[0];
        if (master_ready && data_last)
          state_n = (remaining == BURST_LEN'(1)) ? DONE : RFETCH;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_read   <= 1'b0;
      addr      <= '0;
      burst_lo  <= '0;
      remaining <= '0;
      cnt       <= '0;
      shift     <= '0;
      fresh     <= 1'b0;
`ifdef BRAM_SLAVE_WAIT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (master_valid && (read_en ^ write_en)) begin
          is_read <= read_en;
          cnt     <= '0;
        end
        ADDR: if (master_valid) begin
          addr <= {rx_address, addr[ADDR_LEN-1:1]};
          if (addr_last) begin
            cnt       <= '0;
            remaining <= (burst_full == '0) ? BURST_LEN'(1) : burst_full;
          end else begin
            cnt      <= cnt + 1'b1;
            burst_lo <= {rx_burst, burst_lo[BURST_LEN-2:1]};
          end
        end
        WDATA: if (master_valid) begin
          shift <= {rx_data, shift[DATA_LEN-1:1]};
          cnt   <= data_last ? '0 : cnt + 1'b1;
        end
        WSTORE: begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        RFETCH: begin
          fresh <= 1'b1;
`ifdef BRAM_SLAVE_WAIT_EN
          wait_cnt <= slave_delay;
`endif
        end
`ifdef BRAM_SLAVE_WAIT_EN
        RWAIT: wait_cnt <= wait_cnt - 1'b1;
`endif
        RDATA: if (master_ready) begin
          shift <= rd_word >> 1;
          fresh <= 1'b0;
          if (data_last) begin
            cnt       <= '0;
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
